clk_div_prog: RTL
=================

// Module: clk_div_prog
// PURPOSE
//  Runtime-programmable clock divider. Parametrised successor to the fixed divide-by-14 divider.
//  Generates CLKDV from CLKIN with any divide ratio 2..2^WIDTH-1, loadable while running.
//  Ratio changes take effect only at period boundaries, so CLKDV never has a runt pulse.
//  Drives slow strobes and display/scan clocks in lab designs.
// PARAMETERS
//  WIDTH        8   width of divide ratio and internal counter
//  DEFAULT_DIV  14  ratio after reset; values <2 are clamped to 2
// PORTS
//  CLKIN    in   1      clock; all logic on posedge
//  RST      in   1      synchronous, active-high reset
//  EN       in   1      count enable; 0 freezes counter and CLKDV
//  DIV_IN   in   WIDTH  new divide ratio N
//  DIV_LD   in   1      1-cycle strobe: capture DIV_IN into pending register
//  CLKDV    out  1      divided clock (registered)
//  DIV_CUR  out  WIDTH  ratio currently in effect
//  PEND     out  1      a loaded ratio is waiting for the period boundary
//  DIV_ERR  out  1      sticky: a ratio <2 was loaded and clamped
// BEHAVIOUR
//  - Reset, highest priority: CNT=0, CLKDV=0, DIV_CUR=max(DEFAULT_DIV,2), PEND=0, DIV_ERR=0.
//    Reset mid-period aborts the period; pending load is discarded.
//  - N = DIV_CUR. HI = N>>1. LO = N-HI = (N>>1)+N[0]; compute LO without WIDTH overflow.
//  - Each edge with EN=1: CNT_next = (CNT==N-1) ? 0 : CNT+1; CLKDV <= (CNT_next >= LO).
//    CNT_next==0 is the wrap, i.e. the period boundary.
//  - Waveform: low for LO cycles, then high for HI cycles. Even N gives 50% duty.
//    Odd N gives low one cycle longer than high.
//  - For N=14, CLKDV first rises after edge 7 and falls after edge 14, matching the legacy divider.
//  - EN=0: CNT and CLKDV hold. DIV_LD is still captured. Wrap-time update happens only on enabled edges.
//  - Load: DIV_LD=1 sets PEND_VAL <= DIV_IN and PEND <= 1.
//    Another DIV_LD while PEND=1 overwrites PEND_VAL; last value wins.
//  - Apply: on an enabled wrap edge with PEND=1, DIV_CUR <= PEND_VAL and PEND <= 0.
//    This edge also sets CNT=0 and CLKDV=0.
//  - DIV_LD on the same edge as a wrap applies at that wrap: DIV_CUR <= DIV_IN directly and PEND stays 0.
//  - Clamp: an applied value <2 becomes 2 and sets DIV_ERR.
//    Clamp is evaluated at capture time, so DIV_ERR sets on the DIV_LD edge.
//  - The counter compares against N-1 of the active ratio only. No glitch when the ratio shrinks below the current CNT.
//  - Latency: DIV_LD -> new ratio in effect after at most one old period plus 1 cycle.
// CONFIGURATION
//  - CLK_DIV_TICK_EN defined: extra output TICK (1 bit, reset 0).
//    TICK <= EN && (CNT_next==LO), a 1-CLKIN-cycle pulse coincident with each CLKDV rise.
//    It is intended as a clock-enable for CLKIN-domain logic.
//  - CLK_DIV_TICK_EN undefined: TICK port and its logic are absent. All other behaviour is identical.
// TESTING
//  1. RST 2 cycles, EN=1, no load -> CLKDV 0 for edges 1-6, 1 after edge 7, 0 after edge 14.
//     Period 14; DIV_CUR=14.
//  2. DIV_IN=5, DIV_LD at CNT=3 -> PEND=1 and DIV_CUR=14 until wrap.
//     Then repeating 3 cycles low, 2 high; PEND=0.
//  3. DIV_IN=1, DIV_LD -> DIV_ERR=1 next edge; after wrap DIV_CUR=2 and CLKDV toggles every edge.
//  4. EN=0 for 10 cycles during a high phase (N=14, CNT=9) -> CLKDV stays 1 and CNT stays 9.
//     On resume, 4 more high cycles follow.
//  5. RST mid-period with PEND=1 (PEND_VAL=6) -> next edge CNT=0, CLKDV=0, DIV_CUR=14, PEND=0, DIV_ERR=0.
//  6. With CLK_DIV_TICK_EN, N=6 -> TICK high exactly 1 cycle per 6, on the same edge CLKDV goes 0->1.
//     Also DIV_LD on the wrap edge applies immediately.

Source files
------------

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider (ratio 2..2^WIDTH-1).
// CLKDV is low for LO=ceil(N/2) cycles, then high for HI=floor(N/2) cycles.
// New ratios are held pending and take effect only at a period boundary,
// so CLKDV never produces a runt pulse.
// Optional feature macro: CLK_DIV_TICK_EN adds a TICK output, a one-cycle
// pulse in the CLKIN domain that coincides with each CLKDV rise.
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 14
) (
    input  logic             CLKIN,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV_IN,
    input  logic             DIV_LD,
    output logic             CLKDV,
    output logic [WIDTH-1:0] DIV_CUR,
    output logic             PEND,
    output logic             DIV_ERR
`ifdef CLK_DIV_TICK_EN
   ,output logic             TICK
`endif
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
    localparam logic [WIDTH-1:0] DIV_RST = (DEFAULT_DIV < 2) ? TWO : WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] pend_val;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] ld_val;
    logic             ld_bad;
    logic             wrap;

    // Counter next value, low-phase length and clamped load value.
    // LO is formed as (N>>1)+N[0] so it cannot overflow WIDTH bits.
    always_comb begin
        wrap     = (cnt == (DIV_CUR - ONE));
        cnt_next = wrap ? '0 : (cnt + ONE);
        lo       = (DIV_CUR >> 1) + {{(WIDTH-1){1'b0}}, DIV_CUR[0]};
        ld_bad   = (DIV_IN < TWO);
        ld_val   = ld_bad ? TWO : DIV_IN;
    end

    // Counter, divided clock, ratio load/apply and sticky clamp flag.
    always_ff @(posedge CLKIN) begin
        if (RST) begin
            cnt      <= '0;
            CLKDV    <= 1'b0;
            DIV_CUR  <= DIV_RST;
            pend_val <= DIV_RST;
            PEND     <= 1'b0;
            DIV_ERR  <= 1'b0;
        end else begin
            if (DIV_LD && ld_bad)
                DIV_ERR <= 1'b1;
            if (EN) begin
                cnt   <= cnt_next;
                CLKDV <= (cnt_next >= lo);
            end
            // A load coinciding with an enabled wrap bypasses the pending
            // register and is newer than any value already pending.
            if (EN && wrap && DIV_LD) begin
                DIV_CUR <= ld_val;
                PEND    <= 1'b0;
            end else if (EN && wrap && PEND) begin
                DIV_CUR <= pend_val;
                PEND    <= 1'b0;
            end else if (DIV_LD) begin
                pend_val <= ld_val;
                PEND     <= 1'b1;
            end
        end
    end

`ifdef CLK_DIV_TICK_EN
    // Clock-enable pulse aligned with the edge on which CLKDV rises.
    always_ff @(posedge CLKIN) begin
        if (RST)
            TICK <= 1'b0;
        else
            TICK <= EN && (cnt_next == lo);
    end
`endif

endmodule
